// File: rtl/ena_scheduler_pkg.sv
// Shared constants, types and helpers for the gate-enable scheduler.
// Holds the LFSR definition, default limits and a one-hot to index encoder.
package sched_pkg;

   localparam int                LFSR_W        = 16;
   // Galois right-shift feedback mask for taps 16,14,13,11.
   localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

   localparam int                DEF_N_GATES      = 8;
   localparam int                DEF_STARVE_LIMIT = 16;
   localparam int                DEF_QUIET_LIMIT  = 32;
   localparam logic [LFSR_W-1:0] DEF_LFSR_SEED    = 16'hACE1;

   localparam int MAX_GATES = 256;
   localparam int MAX_IDX_W = 8;

   typedef logic [$clog2(DEF_N_GATES)-1:0] gate_idx_t;

   function automatic logic [MAX_IDX_W-1:0] onehot_idx(input logic [MAX_GATES-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_GATES; i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ena_scheduler_rr_pick.sv
// Cyclic first-set picker: returns the first set bit of cand at or after
// start, wrapping from the top index back to 0.
module rr_pick #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     cand,
   input  logic [IDX_W-1:0] start,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(start) + k) % N;
         if (!any && cand[pos]) begin
            any        = 1'b1;
            idx        = IDX_W'(pos);
            grant[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ena_scheduler.sv
// Picks at most one excited gate per cycle and drives a one-hot-or-zero ena,
// with round-robin/LFSR fairness, anti-starvation override and idle detection.
module ena_scheduler
   import sched_pkg::*;
#(
   parameter int                N_GATES      = DEF_N_GATES,
   parameter int                STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int                QUIET_LIMIT  = DEF_QUIET_LIMIT,
   parameter logic [LFSR_W-1:0] LFSR_SEED    = DEF_LFSR_SEED
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_GATES-1:0]         excited,
   input  logic                       hold,
   input  logic                       rand_mode,
   output logic [N_GATES-1:0]         ena,
   output logic                       fired_valid,
   output logic [$clog2(N_GATES)-1:0] fired_idx,
   output logic                       starve_seen,
   output logic                       quiescent
);

   localparam int                IDX_W    = $clog2(N_GATES);
   localparam int                WAIT_W   = $clog2(STARVE_LIMIT + 1);
   localparam int                IDLE_W   = $clog2(QUIET_LIMIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(QUIET_LIMIT);

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [WAIT_W-1:0] wait_q [N_GATES];
   logic [WAIT_W-1:0] wait_d [N_GATES];
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              fired_valid_q, fired_valid_d;
   logic [IDX_W-1:0]  fired_idx_q, fired_idx_d;
   logic              starve_seen_q, starve_seen_d;
   logic              quiescent_q, quiescent_d;

   logic [N_GATES-1:0] cand, starve_vec, starve_oh, rr_grant, grant;
   logic [IDX_W-1:0]   start, rr_idx, grant_idx;
   logic               rr_any, starve_any, grant_any;

   assign cand = hold ? '0 : excited;

   always_comb begin
      starve_vec = '0;
      for (int i = 0; i < N_GATES; i++) begin
         starve_vec[i] = cand[i] && (wait_q[i] == WAIT_MAX);
      end
   end

   assign starve_any = |starve_vec;
   // Isolate the lowest starving gate.
   assign starve_oh  = starve_vec & (~starve_vec + N_GATES'(1));
   assign start      = rand_mode ? IDX_W'({24'd0, lfsr_q[7:0]} % N_GATES) : ptr_q;

   rr_pick #(
      .N     (N_GATES),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .cand  (cand),
      .start (start),
      .grant (rr_grant),
      .idx   (rr_idx),
      .any   (rr_any)
   );

   assign grant     = starve_any ? starve_oh : rr_grant;
   assign grant_idx = starve_any ? IDX_W'(onehot_idx(MAX_GATES'(starve_oh))) : rr_idx;
   assign grant_any = starve_any | rr_any;
   assign ena       = reset ? '0 : grant;

   always_comb begin
      ptr_d         = ptr_q;
      fired_valid_d = 1'b0;
      fired_idx_d   = fired_idx_q;
      if (grant_any) begin
         ptr_d         = (grant_idx == IDX_W'(N_GATES - 1)) ? '0 : grant_idx + IDX_W'(1);
         fired_valid_d = 1'b1;
         fired_idx_d   = grant_idx;
      end

      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);

      for (int i = 0; i < N_GATES; i++) begin
         wait_d[i] = wait_q[i];
         if (!hold) begin
            if (grant[i] || !excited[i]) wait_d[i] = '0;
            else if (wait_q[i] != WAIT_MAX) wait_d[i] = wait_q[i] + WAIT_W'(1);
         end
      end

      idle_d = idle_q;
      if (!hold) begin
         if (excited != '0) idle_d = '0;
         else if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_W'(1);
      end

      starve_seen_d = starve_seen_q | starve_any;
      quiescent_d   = (idle_d == IDLE_MAX);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= '0;
         lfsr_q        <= LFSR_SEED;
         idle_q        <= '0;
         fired_valid_q <= 1'b0;
         fired_idx_q   <= '0;
         starve_seen_q <= 1'b0;
         quiescent_q   <= 1'b0;
         for (int i = 0; i < N_GATES; i++) wait_q[i] <= '0;
      end else begin
         ptr_q         <= ptr_d;
         lfsr_q        <= lfsr_d;
         idle_q        <= idle_d;
         fired_valid_q <= fired_valid_d;
         fired_idx_q   <= fired_idx_d;
         starve_seen_q <= starve_seen_d;
         quiescent_q   <= quiescent_d;
         for (int i = 0; i < N_GATES; i++) wait_q[i] <= wait_d[i];
      end
   end

   assign fired_valid = fired_valid_q;
   assign fired_idx   = fired_idx_q;
   assign starve_seen = starve_seen_q;
   assign quiescent   = quiescent_q;

endmodule
